// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types, constants and byte-level helpers for the iterative AES-128
// encryption datapath and its controller.
//
// Byte order of every 128-bit block in this codebase:
//   - Bit 0 is the MSB of byte 0.
//   - Byte i occupies bits [8*i : 8*i+7].
//   - Bytes are column-major. Byte i sits in row (i % 4) of column (i / 4),
//     so bytes 0..3 form column 0.
//   - Written as a hex literal, the first two digits are byte 0.
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [0:127] aes_block_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    // Forward S-box, entry 0x00 first. Entry n sits in bits [8n : 8n+7].
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // S-box lookup. The byte value times eight is the table bit offset.
    function automatic aes_byte_t sbox(input aes_byte_t b);
        logic [10:0] idx;
        idx = {b, 3'b000};
        return SBOX_TABLE[idx +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// -----------------------------------------------------------------------------
// aes_round_comb
// One combinational AES encryption round:
//   SubBytes -> ShiftRows -> MixColumns (bypassed when last) -> AddRoundKey.
// This file also holds the three transform blocks that the round is built from.
//
// Ports (aes_round_comb):
//   st         in   128  current cipher state
//   round_key  in   128  round key to add at the end of the round
//   last       in   1    final round: skip MixColumns
//   nxt        out  128  state after this round
// -----------------------------------------------------------------------------

// SubBytes: the S-box applied to each of the 16 bytes on its own.
module aes_sub_bytes
    import aes_pkg::*;
(
    input  aes_block_t state,
    output aes_block_t subbed
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign subbed[i*8 +: 8] = sbox(state[i*8 +: 8]);
    end
endmodule

// ShiftRows: row r rotates left by r columns.
// Output byte (row r, column c) takes input byte (row r, column (c + r) % 4).
module shiftrow127
    import aes_pkg::*;
(
    input  aes_block_t state,
    output aes_block_t shifted
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shifted[(4*c + r)*8 +: 8] = state[(4*((c + r) % 4) + r)*8 +: 8];
        end
    end
endmodule

// MixColumns: each column is multiplied by the circulant matrix {02 03 01 01}.
module aes_mix_columns
    import aes_pkg::*;
(
    input  aes_block_t state,
    output aes_block_t mixed
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        aes_byte_t a0, a1, a2, a3;
        aes_byte_t d0, d1, d2, d3;   // 2*a in GF(2^8); 3*a is then 2*a ^ a

        assign a0 = state[(4*c + 0)*8 +: 8];
        assign a1 = state[(4*c + 1)*8 +: 8];
        assign a2 = state[(4*c + 2)*8 +: 8];
        assign a3 = state[(4*c + 3)*8 +: 8];

        assign d0 = xtime(a0);
        assign d1 = xtime(a1);
        assign d2 = xtime(a2);
        assign d3 = xtime(a3);

        assign mixed[(4*c + 0)*8 +: 8] = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
        assign mixed[(4*c + 1)*8 +: 8] = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
        assign mixed[(4*c + 2)*8 +: 8] = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
        assign mixed[(4*c + 3)*8 +: 8] = (d0 ^ a0) ^ a1 ^ a2 ^ d3;
    end
endmodule

// One full round built from the three transforms above plus the key XOR.
module aes_round_comb
    import aes_pkg::*;
(
    input  aes_block_t st,
    input  aes_block_t round_key,
    input  logic       last,
    output aes_block_t nxt
);
    aes_block_t subbed;
    aes_block_t shifted;
    aes_block_t mixed;
    aes_block_t pre_key;

    aes_sub_bytes u_sub_bytes (
        .state  (st),
        .subbed (subbed)
    );

    shiftrow127 u_shift_rows (
        .state   (subbed),
        .shifted (shifted)
    );

    aes_mix_columns u_mix_columns (
        .state (shifted),
        .mixed (mixed)
    );

    // The final AES round leaves out MixColumns.
    assign pre_key = last ? shifted : mixed;
    assign nxt     = pre_key ^ round_key;
endmodule

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES-128 encryption controller. It accepts one plaintext block,
// applies the initial AddRoundKey, then runs the shared round datapath once
// per clock for NR rounds. Round keys come from an external key store,
// addressed by key_round and returned combinationally on round_key.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    plaintext block offered
//   in_ready   out  1    controller can accept a block (IDLE only)
//   in_data    in   128  plaintext, byte order as in aes_pkg
//   key_round  out  4    round-key index requested from the key store
//   round_key  in   128  round key for key_round, same cycle
//   out_valid  out  1    ciphertext available (DONE only)
//   out_ready  in   1    downstream accepts the ciphertext
//   out_data   out  128  ciphertext, always driven from the state register
//   busy       out  1    high in ROUND and DONE
// -----------------------------------------------------------------------------
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_block_t in_data,
    output logic [3:0] key_round,
    input  aes_block_t round_key,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_block_t out_data,
    output logic       busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    aes_state_e state;
    aes_state_e state_next;
    aes_block_t st;
    aes_block_t round_out;
    logic [3:0] rnd;
    logic       last;
    logic       accept;

    assign last   = (rnd == LAST_RND);
    assign accept = in_valid && in_ready;

    aes_round_comb u_round (
        .st        (st),
        .round_key (round_key),
        .last      (last),
        .nxt       (round_out)
    );

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: clocked processes use non-blocking assignments only, so every
    // register samples its inputs as they stood before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = ROUND;
            ROUND:   if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode: a function of the registered state and rnd only, so
    // key_round never has a combinational path from in_valid or out_ready.
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        key_round = 4'd0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            ROUND: begin
                busy      = 1'b1;
                key_round = rnd;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Cipher state and round counter
    // -------------------------------------------------------------------------
    // NOTE: st is an ordinary flop bank rather than a memory, and it is reset
    // so that out_data reads zero out of reset and an aborted block leaves
    // nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= '0;
            rnd <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Initial AddRoundKey; key_round is 0 in IDLE.
                        st  <= in_data ^ round_key;
                        rnd <= 4'd1;
                    end
                end
                ROUND: begin
                    st <= round_out;
                    // Hold at NR on the last round; the count never wraps.
                    if (!last) begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: begin
                    // DONE: st holds the ciphertext until the handshake.
                end
            endcase
        end
    end

    assign out_data = st;

endmodule

// File: tb/tb_aes_round_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
// Self-checking bench for aes_round_ctrl. The key store is modelled here with
// its own key expansion, built on an S-box derived from the GF(2^8) inverse
// and affine map. Ciphertexts are the published FIPS-197 answers.
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int NR_TB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    aes_block_t in_data;
    logic [3:0] key_round;
    aes_block_t round_key;
    logic       out_valid;
    logic       out_ready;
    aes_block_t out_data;
    logic       busy;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR_TB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_round (key_round),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // ---------------------------------------------------------------- key store
    aes_byte_t  sb [0:255];
    aes_block_t ks [0:2][0:10];
    int         key_sel = 0;

    assign round_key = (key_round <= 4'd10) ? ks[key_sel][int'(key_round)] : '0;

    function automatic aes_byte_t gmul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t p;
        aes_byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        aes_byte_t inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input int sel, input aes_block_t key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        aes_byte_t   rcon;
        for (int i = 0; i < 4; i++) w[i] = key[i*32 +: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ks[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ------------------------------------------------------------------ checks
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ vectors
    typedef struct {
        int         key_sel;
        aes_block_t pt;
        aes_block_t ct;
        logic       early_ready;   // out_ready high during rounds (must be ignored)
    } vec_t;

    vec_t vecs [0:2];

    // One block through the controller with full per-cycle checking.
    task automatic run_block(input vec_t v, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready idle"}, in_ready, 1);
        check({tag, " key_round idle"}, key_round, 0);
        key_sel  = v.key_sel;
        in_data  = v.pt;
        in_valid = 1'b1;
        @(posedge clk);                       // acceptance edge E
        #1;
        in_valid  = 1'b0;
        out_ready = v.early_ready;
        for (int k = 1; k <= NR_TB; k++) begin
            @(negedge clk);
            check($sformatf("%s key_round r%0d", tag, k), key_round, k);
            check($sformatf("%s out_valid low r%0d", tag, k), out_valid, 0);
            check($sformatf("%s in_ready low r%0d", tag, k), in_ready, 0);
            @(posedge clk);
        end
        @(negedge clk);                       // after edge E+NR
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " key_round done"}, key_round, 0);
        check({tag, " busy done"}, busy, 1);
        check({tag, " ciphertext"}, out_data, v.ct);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, " out_valid after hs"}, out_valid, 0);
        check({tag, " in_ready after hs"}, in_ready, 1);
        check({tag, " busy after hs"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------- test
    initial begin
        int         n;
        int         accepts;
        int         outs;
        int         out_cyc [0:3];
        aes_block_t out_dat [0:3];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        build_sbox();
        expand_key(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        expand_key(1, 128'h000102030405060708090a0b0c0d0e0f);
        expand_key(2, 128'h00000000000000000000000000000000);

        vecs[0] = '{0, 128'h3243f6a8885a308d313198a2e0370734,
                       128'h3925841d02dc09fbdc118597196a0b32, 1'b0};
        vecs[1] = '{1, 128'h00112233445566778899aabbccddeeff,
                       128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0};
        vecs[2] = '{2, 128'h00000000000000000000000000000000,
                       128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b1};

        // Reset values, observed while rst is still high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset key_round", key_round, 0);
        check("reset out_data", out_data, 0);
        rst = 1'b0;

        // Table-driven single blocks.
        for (int i = 0; i < 3; i++) run_block(vecs[i], $sformatf("vec%0d", i));

        // Output backpressure: hold out_ready low for 20 cycles.
        @(negedge clk);
        key_sel  = vecs[0].key_sel;
        in_data  = vecs[0].pt;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("bp out_valid", out_valid, 1);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("bp out_data c%0d", i), out_data, vecs[0].ct);
            check($sformatf("bp in_ready c%0d", i), in_ready, 0);
            check($sformatf("bp out_valid c%0d", i), out_valid, 1);
            in_valid = i[0];
            in_data  = vecs[1].pt;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp released out_valid", out_valid, 0);
        check("bp released in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp no extra block c%0d", i), busy, 0);
            @(negedge clk);
        end

        // Back-to-back: in_valid and out_ready held high for two blocks.
        key_sel   = vecs[0].key_sel;
        in_data   = vecs[0].pt;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        accepts   = 0;
        outs      = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (accepts == 2) in_valid = 1'b0;
            if (in_valid && in_ready) accepts++;
            if (out_valid && outs < 4) begin
                out_cyc[outs] = cyc;
                out_dat[outs] = out_data;
                outs++;
                if (outs == 1) begin
                    key_sel = vecs[1].key_sel;
                    in_data = vecs[1].pt;
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b accepts", accepts, 2);
        check("b2b outputs", outs, 2);
        if (outs >= 2) begin
            check("b2b first ct", out_dat[0], vecs[0].ct);
            check("b2b second ct", out_dat[1], vecs[1].ct);
            check("b2b spacing", out_cyc[1] - out_cyc[0], NR_TB + 2);
        end

        // Reset in the middle of round 5.
        @(negedge clk);
        key_sel  = vecs[1].key_sel;
        in_data  = vecs[1].pt;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (key_round != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid key_round 5", key_round, 5);
        rst = 1'b1;
        #1;
        check("mid rst out_valid", out_valid, 0);
        check("mid rst in_ready", in_ready, 1);
        check("mid rst key_round", key_round, 0);
        check("mid rst busy", busy, 0);
        check("mid rst out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        run_block(vecs[1], "post-reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
